m_imem_loader: RTL and testbench

- Host-side program loader: the writer end of the processor's instruction-memory interface.
- Accepts a framed byte stream from the host link (valid/ready), assembles little-endian 32-bit words and drives the write port of the 2K-word instruction memory.
- Holds the processor in halt while loading and releases it after a frame whose checksum verifies.
- Sits between the host byte receiver and the `m_memory` write port/`w_halt` input of `m_proc12` in `m_main`.

---
 rtl/m_imem_loader_pkg.sv | 26 ++
 rtl/m_word_assembler.sv | 41 ++++
 rtl/m_imem_loader.sv | 148 ++++++++++++++
 tb/tb_m_imem_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/m_imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m_imem_loader_pkg
// Brief    : Shared definitions for the instruction-memory program loader:
//            FSM state encodings and the default frame start byte.
// Revision : 1.0 - initial release
// ============================================================================
package m_imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // Default frame start byte
  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/m_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : m_word_assembler
// Brief    : Collects four bytes into a little-endian 32-bit word. The word
//            output already includes the byte being strobed, so the loader
//            can capture the complete word on the 4th byte's accept cycle.
// Revision : 1.0 - initial release
// ============================================================================
module m_word_assembler (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        strobe_i,
  input  logic        clear_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  lane_q;
  logic [31:0] shift_q;

  // Bytes enter at the top and move down, so the first byte ends in [7:0]
  assign word_o      = {data_i, shift_q[31:8]};
  assign word_done_o = strobe_i && (lane_q == 2'd3);

  // Lane counter and shift register; clear has priority over a byte strobe
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      lane_q  <= 2'd0;
      shift_q <= 32'd0;
    end else if (clear_i) begin
      lane_q  <= 2'd0;
      shift_q <= 32'd0;
    end else if (strobe_i) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= {data_i, shift_q[31:8]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/m_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : m_imem_loader
// Brief    : Host-side program loader. Parses framed byte stream
//            (HDR, count lo/hi, 4*N data bytes, checksum), writes the
//            instruction memory and releases processor halt on a good frame.
// Revision : 1.0 - initial release
// ============================================================================
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter logic [7:0]  HDR    = HDR_DEFAULT
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rx_valid,
  input  logic [7:0]        w_rx_data,
  output logic              w_rx_ready,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_halt,
  output logic              r_done,
  output logic              r_err
);

  localparam int unsigned IDX_W     = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       sum_q;

  logic             w_accept;
  logic             w_strobe;
  logic             w_clear;
  logic [15:0]      w_count;
  logic [IDX_W-1:0] w_idx_d;
  logic             w_last;
  logic [7:0]       w_sum_d;
  logic [31:0]      w_word;
  logic             w_word_done;

  // Byte acceptance is blocked only while writing or in the one-cycle exits
  assign w_rx_ready = (state_q != S_WRITE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign w_accept   = w_rx_valid && w_rx_ready;
  assign w_strobe   = w_accept && (state_q == S_DATA);
  assign w_clear    = w_accept && (state_q == S_CNT_HI);
  assign w_count    = {w_rx_data, cnt_q[7:0]};
  assign w_idx_d    = idx_q + 1'b1;
  assign w_last     = (16'(w_idx_d) == cnt_q);
  assign w_sum_d    = sum_q + w_rx_data;

  m_word_assembler u_asm (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .strobe_i    (w_strobe),
    .clear_i     (w_clear),
    .data_i      (w_rx_data),
    .word_o      (w_word),
    .word_done_o (w_word_done)
  );

  // Frame parser FSM with registered memory-port and status outputs
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      sum_q   <= 8'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_halt  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (w_accept && (w_rx_data == HDR)) begin
            state_q <= S_CNT_LO;
            r_halt  <= 1'b1;
            r_err   <= 1'b0;
            sum_q   <= 8'd0;
          end
        end
        S_CNT_LO: begin
          if (w_accept) begin
            cnt_q[7:0] <= w_rx_data;
            sum_q      <= w_sum_d;
            state_q    <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (w_accept) begin
            cnt_q <= w_count;
            sum_q <= w_sum_d;
            idx_q <= '0;
            if ({1'b0, w_count} > MAX_WORDS) begin
              state_q <= S_ERR;
              r_err   <= 1'b1;
            end else if (w_count == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_strobe) begin
            sum_q <= w_sum_d;
            if (w_word_done) begin
              r_we    <= 1'b1;
              r_addr  <= idx_q[ADDR_W-1:0];
              r_wdata <= w_word;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          idx_q   <= w_idx_d;
          state_q <= w_last ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (w_accept) begin
            if (w_sum_d == 8'd0) begin
              state_q <= S_DONE;
              r_done  <= 1'b1;
              r_halt  <= 1'b0;
            end else begin
              state_q <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_imem_loader
// Brief    : Directed self-checking bench for the program loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_imem_loader;
  import m_imem_loader_pkg::*;

  logic        w_clk;
  logic        w_rst;
  logic        w_rx_valid;
  logic [7:0]  w_rx_data;
  logic        w_rx_ready;
  logic        r_we;
  logic [10:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_halt;
  logic        r_done;
  logic        r_err;

  int n_checks = 0;
  int n_errors = 0;

  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_data = 32'd0;

  m_imem_loader #(.ADDR_W(11), .HDR(8'hA5)) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_rx_valid (w_rx_valid),
    .w_rx_data  (w_rx_data),
    .w_rx_ready (w_rx_ready),
    .r_we       (r_we),
    .r_addr     (r_addr),
    .r_wdata    (r_wdata),
    .r_halt     (r_halt),
    .r_done     (r_done),
    .r_err      (r_err)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Record memory writes and done pulses in the stable low phase
  always @(negedge w_clk) begin
    if (r_we) begin
      wr_cnt++;
      last_addr = 32'(r_addr);
      last_data = r_wdata;
    end
    if (r_done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    w_rx_valid = 1'b1;
    w_rx_data  = b;
    while (!w_rx_ready && t < 20) begin
      @(negedge w_clk);
      t++;
    end
    if (t >= 20) check_eq("rx_ready_timeout", 32'(w_rx_ready), 32'd1);
    @(negedge w_clk);
    w_rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge w_clk);
    send_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge w_clk);
  endtask

  int          wr_base;
  int          done_base;
  logic [7:0]  csum;
  logic [15:0] k16;

  initial begin
    w_rst      = 1'b1;
    w_rx_valid = 1'b0;
    w_rx_data  = 8'h00;
    idle(2);
    check_eq("rst_halt",  32'(r_halt), 32'd1);
    check_eq("rst_we",    32'(r_we), 32'd0);
    check_eq("rst_done",  32'(r_done), 32'd0);
    check_eq("rst_err",   32'(r_err), 32'd0);
    check_eq("rst_addr",  32'(r_addr), 32'd0);
    check_eq("rst_wdata", r_wdata, 32'd0);
    check_eq("rst_ready", 32'(w_rx_ready), 32'd1);
    w_rst = 1'b0;
    idle(1);

    // Good 2-word frame; bytes after HDR sum to 0x77, so checksum 0x89
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_eq("f1_w0_we",    32'(r_we), 32'd1);
    check_eq("f1_w0_addr",  32'(r_addr), 32'd0);
    check_eq("f1_w0_data",  r_wdata, 32'h0000_0020);
    check_eq("f1_w0_ready", 32'(w_rx_ready), 32'd0);
    send_byte(8'h11); send_byte(8'h00); send_byte(8'h00); send_byte(8'h44);
    check_eq("f1_w1_we",   32'(r_we), 32'd1);
    check_eq("f1_w1_addr", 32'(r_addr), 32'd1);
    check_eq("f1_w1_data", r_wdata, 32'h4400_0011);
    check_eq("f1_halt_pre", 32'(r_halt), 32'd1);
    send_byte(8'h89);
    check_eq("f1_done", 32'(r_done), 32'd1);
    check_eq("f1_halt", 32'(r_halt), 32'd0);
    idle(2); #1;
    check_eq("f1_wr_cnt",   32'(wr_cnt), 32'd2);
    check_eq("f1_done_cnt", 32'(done_cnt), 32'd1);

    // Same frame with a bad checksum
    wr_base = wr_cnt; done_base = done_cnt;
    send_byte(8'hA5);
    check_eq("f2_rehalt", 32'(r_halt), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h00); send_byte(8'h00); send_byte(8'h44);
    send_byte(8'h8C);
    check_eq("f2_err",  32'(r_err), 32'd1);
    check_eq("f2_halt", 32'(r_halt), 32'd1);
    check_eq("f2_done", 32'(r_done), 32'd0);
    idle(3); #1;
    check_eq("f2_err_sticky", 32'(r_err), 32'd1);
    check_eq("f2_wr_cnt",     32'(wr_cnt - wr_base), 32'd2);
    check_eq("f2_done_cnt",   32'(done_cnt - done_base), 32'd0);
    check_eq("f2_halt_hold",  32'(r_halt), 32'd1);

    // Garbage before header, then an empty frame
    wr_base = wr_cnt; done_base = done_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    check_eq("f3_garbage_err", 32'(r_err), 32'd1);
    send_byte(8'hA5);
    check_eq("f3_err_clear", 32'(r_err), 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_eq("f3_done", 32'(r_done), 32'd1);
    check_eq("f3_halt", 32'(r_halt), 32'd0);
    idle(2); #1;
    check_eq("f3_wr_cnt",   32'(wr_cnt - wr_base), 32'd0);
    check_eq("f3_done_cnt", 32'(done_cnt - done_base), 32'd1);

    // Oversized count 0x0801, trailing bytes land in IDLE
    wr_base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h08);
    check_eq("f4_err",   32'(r_err), 32'd1);
    check_eq("f4_halt",  32'(r_halt), 32'd1);
    check_eq("f4_ready", 32'(w_rx_ready), 32'd0);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    idle(2); #1;
    check_eq("f4_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
    check_eq("f4_state",  32'(dut.state_q), 32'(S_IDLE));

    // Gapped frame aborted by reset after 6 data bytes
    wr_base = wr_cnt;
    send_gap(8'hA5); send_gap(8'h02); send_gap(8'h00);
    send_gap(8'h01); send_gap(8'h02); send_gap(8'h03); send_gap(8'h04);
    send_gap(8'h05); send_gap(8'h06);
    w_rst = 1'b1;
    #1;
    check_eq("f5_rst_halt",  32'(r_halt), 32'd1);
    check_eq("f5_rst_we",    32'(r_we), 32'd0);
    check_eq("f5_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    idle(2);
    w_rst = 1'b0;
    idle(1); #1;
    check_eq("f5_wr_cnt",    32'(wr_cnt - wr_base), 32'd1);
    check_eq("f5_wr_addr",   last_addr, 32'd0);
    check_eq("f5_wr_data",   last_data, 32'h0403_0201);

    // Good frame after abort; 01+DE+AD+BE+EF = 0x39 mod 256, checksum 0xC7
    send_gap(8'hA5); send_gap(8'h01); send_gap(8'h00);
    send_gap(8'hDE); send_gap(8'hAD); send_gap(8'hBE); send_byte(8'hEF);
    check_eq("f6_we",   32'(r_we), 32'd1);
    check_eq("f6_addr", 32'(r_addr), 32'd0);
    check_eq("f6_data", r_wdata, 32'hEFBE_ADDE);
    send_gap(8'hC7);
    check_eq("f6_done", 32'(r_done), 32'd1);
    check_eq("f6_halt", 32'(r_halt), 32'd0);

    // Header while running re-halts on the next cycle
    idle(2);
    send_byte(8'hA5);
    check_eq("f7_rehalt", 32'(r_halt), 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_eq("f7_done", 32'(r_done), 32'd1);

    // Largest legal frame: 2048 words, word k = k
    wr_base = wr_cnt;
    csum = 8'h08;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h08);
    for (int k = 0; k < 2048; k++) begin
      k16 = 16'(k);
      csum = csum + k16[7:0] + k16[15:8];
      send_byte(k16[7:0]); send_byte(k16[15:8]);
      send_byte(8'h00); send_byte(8'h00);
    end
    send_byte(8'h00 - csum);
    check_eq("f8_done", 32'(r_done), 32'd1);
    check_eq("f8_halt", 32'(r_halt), 32'd0);
    idle(2); #1;
    check_eq("f8_wr_cnt", 32'(wr_cnt - wr_base), 32'd2048);
    check_eq("f8_last_addr", last_addr, 32'h7FF);
    check_eq("f8_last_data", last_data, 32'h7FF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
